// File: rtl/accum_pkg.sv
// Shared definitions for the two-requester accumulator arbiter.
//   ACC_W      : default accumulator / magnitude width.
//   OP_SUB_BIT : bit position of the subtract flag in an op word at that width.
//   OWN_A/B    : values carried by owner_o and the round-robin pointer.
//   state_t    : FSM encodings (IDLE, EXEC, ACK).
//   pick_owner : round-robin choice between the two requesters.
package accum_pkg;

    localparam int ACC_W      = 8;
    localparam int OP_SUB_BIT = ACC_W;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Returns the requester to serve, given that at least one request is
    // high. On a tie the requester that was NOT granted last wins, which
    // gives strict alternation under continuous contention.
    function automatic logic pick_owner(input logic req_a,
                                        input logic req_b,
                                        input logic last_owner);
        logic sel;
        if (req_a && req_b) begin
            sel = ~last_owner;
        end else if (req_a) begin
            sel = OWN_A;
        end else begin
            sel = OWN_B;
        end
        return sel;
    endfunction

endpackage

// File: rtl/accum_core.sv
// Datapath of the shared accumulator.
//   clk     : rising-edge clock
//   clr     : asynchronous active-high reset
//   en      : apply op this cycle (asserted by the arbiter in EXEC)
//   op      : [W] = subtract, [W-1:0] = magnitude
//   clr_acc : synchronous clear of acc, carry and sticky
//   acc     : accumulator value
//   carry   : bit W of the last 9-bit result (carry on add, borrow on sub)
//   sticky  : set by any result with carry=1, cleared by clr_acc / clr
module accum_core
    import accum_pkg::*;
#(
    parameter int W = ACC_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W:0]   op,
    input  logic         clr_acc,
    output logic [W-1:0] acc,
    output logic         carry,
    output logic         sticky
);

    // The package constant describes the default width; any other width
    // keeps the subtract flag in the top bit of the op word.
    localparam int SUB_BIT = (W == ACC_W) ? OP_SUB_BIT : W;

    logic [W-1:0] acc_reg;
    logic         carry_reg;
    logic         sticky_reg;
    logic [W:0]   result_next;

    // One extra bit on both operands: bit W is the carry out of an add or
    // the borrow of a subtract (two's-complement wrap sets it).
    always_comb begin
        result_next = '0;
        if (op[SUB_BIT]) begin
            result_next = {1'b0, acc_reg} - {1'b0, op[W-1:0]};
        end else begin
            result_next = {1'b0, acc_reg} + {1'b0, op[W-1:0]};
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            acc_reg    <= '0;
            carry_reg  <= 1'b0;
            sticky_reg <= 1'b0;
        end else if (clr_acc) begin
            acc_reg    <= '0;
            carry_reg  <= 1'b0;
            sticky_reg <= 1'b0;
        end else if (en) begin
            acc_reg   <= result_next[W-1:0];
            carry_reg <= result_next[W];
            if (result_next[W]) begin
                sticky_reg <= 1'b1;
            end
        end
    end

    assign acc    = acc_reg;
    assign carry  = carry_reg;
    assign sticky = sticky_reg;

endmodule

// File: rtl/accum_arbiter.sv
// Round-robin arbiter sharing one add/subtract accumulator between two
// requesters A and B. Each op takes IDLE (grant) -> EXEC (apply) -> ACK
// (one-cycle acknowledge to the owner), i.e. at least three cycles per op.
//   clk, clr          : clock, asynchronous active-high reset
//   req_a/op_a/ack_a  : requester A handshake; op[W]=subtract, op[W-1:0]=mag
//   req_b/op_b/ack_b  : requester B handshake
//   clr_acc           : request to zero acc and flags (applied in IDLE)
//   acc_o, carry_o    : accumulator value and carry/borrow of last result
//   ovf_sticky_o      : sticky record of any carry/borrow
//   busy_o            : high outside IDLE
//   owner_o           : most recently granted requester (0=A, 1=B)
module accum_arbiter
    import accum_pkg::*;
#(
    parameter int W = ACC_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         req_a,
    input  logic [W:0]   op_a,
    output logic         ack_a,
    input  logic         req_b,
    input  logic [W:0]   op_b,
    output logic         ack_b,
    input  logic         clr_acc,
    output logic [W-1:0] acc_o,
    output logic         carry_o,
    output logic         ovf_sticky_o,
    output logic         busy_o,
    output logic         owner_o
);

    state_t       state_reg;
    logic         owner_reg;
    logic [W:0]   op_reg;
    logic         pend_clr_reg;
    logic [1:0]   ack_reg;

    logic         clear_now;
    logic         grant_valid;
    logic         grant_sel;
    logic [W:0]   grant_op;

    // A clear requested while an op was in flight is held in pend_clr_reg
    // and takes priority over any grant in the next IDLE cycle.
    assign clear_now = (state_reg == ST_IDLE) && (pend_clr_reg || clr_acc);

    always_comb begin
        grant_valid = 1'b0;
        grant_sel   = owner_reg;
        if ((state_reg == ST_IDLE) && !clear_now && (req_a || req_b)) begin
            grant_valid = 1'b1;
            grant_sel   = pick_owner(req_a, req_b, owner_reg);
        end
        grant_op = (grant_sel == OWN_B) ? op_b : op_a;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= OWN_B;     // so A wins the first tie
            op_reg       <= '0;
            pend_clr_reg <= 1'b0;
            ack_reg      <= 2'b00;
        end else begin
            ack_reg <= 2'b00;
            case (state_reg)
                ST_IDLE: begin
                    if (clear_now) begin
                        pend_clr_reg <= 1'b0;
                    end else if (grant_valid) begin
                        op_reg    <= grant_op;
                        owner_reg <= grant_sel;
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (clr_acc) begin
                        pend_clr_reg <= 1'b1;
                    end
                    // The core updates acc on this same edge, so the ack
                    // and the new result become visible together.
                    ack_reg   <= (owner_reg == OWN_B) ? 2'b10 : 2'b01;
                    state_reg <= ST_ACK;
                end
                ST_ACK: begin
                    if (clr_acc) begin
                        pend_clr_reg <= 1'b1;
                    end
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    accum_core #(
        .W(W)
    ) u_core (
        .clk     (clk),
        .clr     (clr),
        .en      (state_reg == ST_EXEC),
        .op      (op_reg),
        .clr_acc (clear_now),
        .acc     (acc_o),
        .carry   (carry_o),
        .sticky  (ovf_sticky_o)
    );

    assign ack_a   = ack_reg[OWN_A];
    assign ack_b   = ack_reg[OWN_B];
    assign busy_o  = (state_reg != ST_IDLE);
    assign owner_o = owner_reg;

endmodule

// File: tb/tb_accum_arbiter.sv
module tb_accum_arbiter;

    logic       clk;
    logic       clr;
    logic       req_a;
    logic [8:0] op_a;
    logic       ack_a;
    logic       req_b;
    logic [8:0] op_b;
    logic       ack_b;
    logic       clr_acc;
    logic [7:0] acc_o;
    logic       carry_o;
    logic       ovf_sticky_o;
    logic       busy_o;
    logic       owner_o;

    int n_checks = 0;
    int n_fail   = 0;

    accum_arbiter dut (
        .clk          (clk),
        .clr          (clr),
        .req_a        (req_a),
        .op_a         (op_a),
        .ack_a        (ack_a),
        .req_b        (req_b),
        .op_b         (op_b),
        .ack_b        (ack_b),
        .clr_acc      (clr_acc),
        .acc_o        (acc_o),
        .carry_o      (carry_o),
        .ovf_sticky_o (ovf_sticky_o),
        .busy_o       (busy_o),
        .owner_o      (owner_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       clr_first;
        logic       use_b;
        logic [8:0] op;
        logic [7:0] acc;
        logic       carry;
        logic       sticky;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ack_of(input logic use_b);
        return use_b ? ack_b : ack_a;
    endfunction

    task automatic do_clear();
        clr_acc = 1'b1;
        tick();
        clr_acc = 1'b0;
        check("clear/acc", acc_o, 0);
        check("clear/carry", carry_o, 0);
        check("clear/sticky", ovf_sticky_o, 0);
        check("clear/no_grant", busy_o, 0);
        $display("clear: acc=%h carry=%0d sticky=%0d", acc_o, carry_o, ovf_sticky_o);
    endtask

    // Single op from IDLE: grant on the first edge, ack + result on the second.
    task automatic do_op(input string tag, input logic use_b, input logic [8:0] op,
                         input logic [7:0] e_acc, input logic e_carry, input logic e_sticky);
        if (use_b) begin
            req_b = 1'b1;
            op_b  = op;
        end else begin
            req_a = 1'b1;
            op_a  = op;
        end
        tick();
        check({tag, "/busy"}, busy_o, 1);
        check({tag, "/owner"}, owner_o, use_b);
        tick();
        check({tag, "/ack_latency"}, ack_of(use_b), 1);
        check({tag, "/other_ack"}, ack_of(!use_b), 0);
        for (int i = 0; i < 8 && !ack_of(use_b); i++) tick();
        check({tag, "/acc"}, acc_o, e_acc);
        check({tag, "/carry"}, carry_o, e_carry);
        check({tag, "/sticky"}, ovf_sticky_o, e_sticky);
        $display("op %s: req=%s op=%h -> acc=%h carry=%0d sticky=%0d",
                 tag, use_b ? "B" : "A", op, acc_o, carry_o, ovf_sticky_o);
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        check({tag, "/ack_pulse"}, ack_of(use_b), 0);
        check({tag, "/idle"}, busy_o, 0);
    endtask

    // contention bookkeeping
    int exp_who [4] = '{0, 1, 0, 1};
    int exp_acc [4] = '{1, 17, 18, 34};
    int got_who [4];
    int got_acc [4];
    int got_cyc [4];
    int n_ack;

    // random-phase reference model (transaction level)
    int         m_acc;
    logic       m_carry;
    logic       m_sticky;
    int         res;
    logic       rq [2];
    logic [8:0] rop [2];
    int         waitc [2];
    int         pend_cyc [2];
    int         clr_cd;
    logic       allow;

    initial begin
        clr     = 1'b1;
        req_a   = 1'b0;
        req_b   = 1'b0;
        op_a    = '0;
        op_b    = '0;
        clr_acc = 1'b0;

        vecs[0]  = '{1'b0, 1'b0, 9'h005, 8'h05, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 9'h102, 8'h03, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 9'h105, 8'hFE, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 9'h001, 8'hFF, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 9'h0F0, 8'hF0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 9'h020, 8'h10, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 9'h1FF, 8'h11, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 9'h100, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 9'h0FF, 8'hFF, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 9'h001, 8'h00, 1'b1, 1'b1};

        // ---- reset values
        tick();
        tick();
        check("rst/acc", acc_o, 0);
        check("rst/carry", carry_o, 0);
        check("rst/sticky", ovf_sticky_o, 0);
        check("rst/ack_a", ack_a, 0);
        check("rst/ack_b", ack_b, 0);
        check("rst/busy", busy_o, 0);
        check("rst/owner", owner_o, 1);
        clr = 1'b0;

        // ---- table of single ops
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].clr_first) do_clear();
            do_op($sformatf("vec%0d", i), vecs[i].use_b, vecs[i].op,
                  vecs[i].acc, vecs[i].carry, vecs[i].sticky);
        end

        // ---- contention from reset: both held high
        clr   = 1'b1;
        req_a = 1'b1;
        op_a  = 9'h001;
        req_b = 1'b1;
        op_b  = 9'h010;
        tick();
        clr   = 1'b0;
        n_ack = 0;
        for (int c = 1; c <= 30 && n_ack < 4; c++) begin
            tick();
            check("cont/ack_exclusive", ack_a & ack_b, 0);
            if (ack_a || ack_b) begin
                got_who[n_ack] = ack_b ? 1 : 0;
                got_acc[n_ack] = acc_o;
                got_cyc[n_ack] = c;
                $display("contention ack %0d: %s acc=%0d cycle=%0d", n_ack, ack_b ? "B" : "A", acc_o, c);
                n_ack++;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        check("cont/ack_count", n_ack, 4);
        for (int i = 0; i < n_ack; i++) begin
            check($sformatf("cont/who%0d", i), got_who[i], exp_who[i]);
            check($sformatf("cont/acc%0d", i), got_acc[i], exp_acc[i]);
            if (i == 0) check("cont/first_latency", got_cyc[0], 2);
            else check($sformatf("cont/spacing%0d", i), got_cyc[i] - got_cyc[i-1], 3);
        end
        tick();
        tick();

        // ---- clr_acc during EXEC, with B waiting
        do_clear();
        do_op("h3pre", 1'b1, 9'h002, 8'h02, 1'b0, 1'b0);
        req_a = 1'b1;
        op_a  = 9'h007;
        tick();
        check("h3/grant_a", owner_o, 0);
        check("h3/busy_exec", busy_o, 1);
        clr_acc = 1'b1;
        req_b   = 1'b1;
        op_b    = 9'h003;
        tick();
        clr_acc = 1'b0;
        check("h3/ack_a", ack_a, 1);
        check("h3/ack_b_low", ack_b, 0);
        check("h3/acc_at_ack", acc_o, 9);
        req_a = 1'b0;
        tick();
        check("h3/ack_pulse", ack_a, 0);
        check("h3/acc_held", acc_o, 9);
        tick();
        check("h3/cleared", acc_o, 0);
        check("h3/no_grant_on_clear", busy_o, 0);
        tick();
        check("h3/b_granted", busy_o, 1);
        check("h3/b_owner", owner_o, 1);
        tick();
        check("h3/ack_b", ack_b, 1);
        check("h3/acc_b", acc_o, 3);
        $display("clr during EXEC: B acked acc=%h", acc_o);
        req_b = 1'b0;
        tick();

        // ---- clr_acc and req in the same IDLE cycle
        req_a   = 1'b1;
        op_a    = 9'h004;
        clr_acc = 1'b1;
        tick();
        clr_acc = 1'b0;
        check("h4/clear_wins", acc_o, 0);
        check("h4/no_grant", busy_o, 0);
        tick();
        check("h4/granted_next", busy_o, 1);
        check("h4/owner", owner_o, 0);
        tick();
        check("h4/ack_a", ack_a, 1);
        check("h4/acc", acc_o, 4);
        $display("clr+req same cycle: A acked acc=%h", acc_o);
        req_a = 1'b0;
        tick();

        // ---- asynchronous reset during EXEC
        do_op("h5pre", 1'b0, 9'h1FF, 8'h05, 1'b1, 1'b1);
        req_a = 1'b1;
        op_a  = 9'h011;
        tick();
        #2;
        clr = 1'b1;
        #1;
        check("h5/async_acc", acc_o, 0);
        check("h5/async_carry", carry_o, 0);
        check("h5/async_sticky", ovf_sticky_o, 0);
        check("h5/async_busy", busy_o, 0);
        check("h5/async_owner", owner_o, 1);
        check("h5/async_ack", ack_a, 0);
        tick();
        check("h5/no_ack_in_reset", ack_a, 0);
        clr   = 1'b0;
        n_ack = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ack_a) begin
                n_ack++;
                check("h5/acc_after_reserve", acc_o, 8'h11);
                req_a = 1'b0;
            end
        end
        check("h5/ack_once", n_ack, 1);
        $display("async reset mid-op: re-served acks=%0d acc=%h", n_ack, acc_o);
        req_a = 1'b0;

        // ---- randomized traffic vs. transaction-level model
        clr = 1'b1;
        tick();
        clr      = 1'b0;
        m_acc    = 0;
        m_carry  = 1'b0;
        m_sticky = 1'b0;
        clr_cd   = 0;
        for (int x = 0; x < 2; x++) begin
            rq[x]       = 1'b0;
            rop[x]      = '0;
            waitc[x]    = 0;
            pend_cyc[x] = 0;
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            tick();
            clr_acc = 1'b0;
            allow   = (cyc < 740);
            check("rnd/ack_exclusive", ack_a & ack_b, 0);
            if (clr_cd > 0) begin
                clr_cd--;
                if (clr_cd == 0) begin
                    check("rnd/clear_acc", acc_o, 0);
                    check("rnd/clear_sticky", ovf_sticky_o, 0);
                    check("rnd/clear_no_grant", busy_o, 0);
                end
            end
            for (int x = 0; x < 2; x++) begin
                if (ack_of(x[0])) begin
                    check("rnd/ack_has_req", rq[x], 1);
                    if (rop[x][8]) res = m_acc - int'(rop[x][7:0]);
                    else res = m_acc + int'(rop[x][7:0]);
                    m_carry  = (res < 0) || (res > 255);
                    m_acc    = ((res % 256) + 256) % 256;
                    m_sticky = m_sticky | m_carry;
                    check("rnd/acc", acc_o, m_acc);
                    check("rnd/carry", carry_o, m_carry);
                    check("rnd/sticky", ovf_sticky_o, m_sticky);
                    check("rnd/owner", owner_o, x);
                    check("rnd/fairness", waitc[x] <= 1, 1);
                    $display("rnd cyc %0d: ack %s op=%h acc=%h carry=%0d sticky=%0d",
                             cyc, (x == 1) ? "B" : "A", rop[x], acc_o, carry_o, ovf_sticky_o);
                    if (rq[1-x]) waitc[1-x]++;
                    waitc[x]    = 0;
                    pend_cyc[x] = 0;
                    if (allow && ($urandom % 10) < 6) rop[x] = 9'($urandom_range(0, 511));
                    else rq[x] = 1'b0;
                    if (allow && ($urandom % 6) == 0) begin
                        clr_acc  = 1'b1;
                        m_acc    = 0;
                        m_carry  = 1'b0;
                        m_sticky = 1'b0;
                        clr_cd   = 2;
                    end
                end else if (rq[x]) begin
                    pend_cyc[x]++;
                    check("rnd/pending_bound", pend_cyc[x] <= 12, 1);
                end else if (allow && ($urandom % 10) < 3) begin
                    rq[x]       = 1'b1;
                    rop[x]      = 9'($urandom_range(0, 511));
                    waitc[x]    = 0;
                    pend_cyc[x] = 0;
                end
            end
            req_a = rq[0];
            op_a  = rop[0];
            req_b = rq[1];
            op_b  = rop[1];
        end
        check("rnd/drained_a", rq[0], 0);
        check("rnd/drained_b", rq[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accum_arbiter.md
Name: accum_arbiter

Overview:
- Shares one 8-bit add/subtract accumulator between two independent requesters, A and B.
- Each requester presents a signed-op word: bit W selects subtract, bits [W-1:0] are the magnitude. The block round-robin arbitrates, sequences the accumulate, and returns a one-cycle acknowledge.
- Sits between lab-top switch/key front-ends, or two producer FSMs, and the LEDR/HEX result display.

Parameters:
- W, 8, accumulator and magnitude width; op words are W+1 bits.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous active-high reset.
- req_a  in  1  requester A wants an op performed; held high until ack_a.
- op_a  in  W+1  A's op: [W]=1 subtract, [W-1:0] magnitude; stable while req_a is high.
- ack_a  out  1  one-cycle pulse: A's op has been applied.
- req_b  in  1  as req_a, for requester B.
- op_b  in  W+1  as op_a, for requester B.
- ack_b  out  1  as ack_a, for requester B.
- clr_acc  in  1  synchronous request to zero the accumulator and flags; single-cycle pulse allowed.
- acc_o  out  W  current accumulator value.
- carry_o  out  1  bit W of the last 9-bit result (carry on add, borrow on subtract).
- ovf_sticky_o  out  1  set when any op produces carry_o=1; cleared only by clr_acc or clr.
- busy_o  out  1  high in every state except IDLE.
- owner_o  out  1  0=A, 1=B; the requester granted most recently.

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE; acc_o=0; carry_o=0; ovf_sticky_o=0; ack_a=ack_b=0; busy_o=0; owner_o=1, so A wins the first tie; pending-clear flag=0.
- Reset mid-operation: the in-flight op is discarded, no ack is issued, and the requester must re-present it.
- FSM states: IDLE, EXEC, ACK.
- IDLE:
  - If the pending-clear flag or clr_acc is set: zero acc, carry and sticky; clear the pending flag; stay in IDLE; grant nothing this cycle.
  - Else if exactly one req is high: grant it.
  - Else if both are high: grant the requester opposite owner_o.
  - On grant: latch its op, update owner_o, go to EXEC.
- EXEC: {carry, acc} <= {1'b0, acc} + mag, or {1'b0, acc} - mag when op[W]=1, in 9-bit arithmetic; acc wraps modulo 2^W. Set sticky if carry. Go to ACK.
- ACK: pulse ack of the owner for exactly one cycle; acc_o and carry_o already show the new result. Go to IDLE.
- Latency and throughput:
  - Request sampled in IDLE at edge k; result visible after edge k+1; ack high during cycle k+2.
  - Minimum 3 cycles per op.
- Back-to-back ops: a req still high in the IDLE cycle after its ack is a new op.
  - With both requesters continuously requesting, grants strictly alternate A, B, A, ...
  - No requester waits more than one other op.
- clr_acc asserted in EXEC or ACK sets the pending-clear flag. The clear is applied in the next IDLE cycle, before any grant. The op already in flight still completes and is acked.
- clr_acc and req in the same IDLE cycle: the clear wins; the req is served next cycle.
- ack_a and ack_b are never high together; ack is never issued without a preceding grant.
- Ops are never lost or duplicated while clr is low.
- req dropped before ack is a protocol violation, behaviour undefined. The latched op still completes.

Decomposition:
- Shared package accum_pkg:
  - state encodings ST_IDLE, ST_EXEC, ST_ACK.
  - OP_SUB_BIT = W.
  - owner constants OWN_A=0, OWN_B=1.
- Sub-module accum_core holds the datapath:
  - acc register, carry, sticky, 9-bit add/sub.
  - inputs: clk, clr, en, op, clr_acc.
- accum_arbiter contains the FSM, round-robin pointer, op latch and pending-clear flag.

Test Plan:
- Reset, then A alone: op_a=9'h005 → ack_a at cycle 2 after sample; acc_o=5, carry_o=0, owner_o=0.
- Subtract with borrow: acc=3, B op_b=9'h105 → acc_o=8'hFE, carry_o=1, ovf_sticky_o=1; a following add 9'h001 gives acc_o=8'hFF, carry_o=0, sticky stays 1.
- Contention: req_a and req_b held high from reset with op_a=9'h001 and op_b=9'h010 → ack order A, B, A, B; acc_o sequence 1, 17, 18, 34; acks 3 cycles apart.
- Add wrap: acc=8'hF0, op 9'h020 → acc_o=8'h10, carry_o=1, sticky=1.
- clr_acc pulsed during EXEC of op 9'h007 from acc=2 → ack shows acc_o=9, next IDLE clears to 0 with no grant, and a waiting req is granted the following cycle.
- clr asserted asynchronously in EXEC → all outputs at reset values immediately and no ack; after release the held req is re-served and acked once.
